sel_scan: RTL and testbench
===========================

SEL_SCAN -- requirements
Module: sel_scan

Interface
REQ-001 Parameter DEB_CNT_MAX, default 20'd999_999: debounce terminal count, 20 ms at 50 MHz.
REQ-002 Parameter DWELL_MAX, default 26'd49_999_999: auto-step terminal count, 1 s at 50 MHz.
REQ-003 Port sys_clk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port sys_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port key_in, input, 1: raw, asynchronous, bouncing push-button; 0 = pressed.
REQ-006 Port mode, input, 1: 0 = manual (step per key press), 1 = auto (step per dwell period).
REQ-007 Port a, output, 2: registered select code driving the downstream 2-to-4 LED decoder.
REQ-008 Port a_vld, output, 1: one-cycle pulse, asserted in the same cycle a takes a new value.

Function
REQ-009 key_in SHALL pass through a 2-flop synchronizer (key_s2) before any use.
REQ-010 The debounce FSM SHALL have four states: IDLE, PRESS_FILT, HOLD, REL_FILT.
REQ-011 IDLE: key_s2=0 -> PRESS_FILT with deb_cnt=0.
REQ-012 PRESS_FILT: deb_cnt increments while key_s2=0; key_s2=1 -> IDLE; deb_cnt==DEB_CNT_MAX -> HOLD and a one-cycle key_flag pulse.
REQ-013 HOLD: remains in HOLD while key_s2=0; key_s2=1 -> REL_FILT with deb_cnt=0.
REQ-014 REL_FILT: deb_cnt increments while key_s2=1; key_s2=0 -> HOLD; deb_cnt==DEB_CNT_MAX -> IDLE.
REQ-015 Exactly one key_flag SHALL be produced per debounced press, regardless of hold time or bounce count.
REQ-016 Manual mode: each key_flag SHALL step a once; dwell_cnt is held at 0.
REQ-017 Auto mode: dwell_cnt increments every cycle; at DWELL_MAX it wraps to 0 and a steps once; key_flag is ignored.
REQ-018 Any change of mode SHALL clear dwell_cnt in the following cycle; a SHALL hold its value.
REQ-019 Step direction: up 0->1->2->3->0 (wraps 3->0); down (when enabled) 3->2->1->0->3 (wraps 0->3).
REQ-020 Latency: a and a_vld SHALL update one cycle after key_flag, or one cycle after dwell_cnt==DWELL_MAX.
REQ-021 a_vld SHALL be 0 in every cycle in which a does not change.
REQ-022 deb_cnt and dwell_cnt SHALL be sized to their parameter widths and SHALL never exceed their MAX value.

Reset
REQ-023 With sys_rst_n=0 at a rising edge: a=2'b00, a_vld=0, FSM=IDLE, deb_cnt=0, dwell_cnt=0, synchronizer flops=1.
REQ-024 Reset asserted in mid-filter or mid-dwell SHALL abandon the operation; no pulse SHALL be emitted for it.
REQ-025 A key held low across reset release SHALL be debounced from IDLE and SHALL count as a new press.

Configuration
REQ-026 Macro SEL_DOWN_EN defined: adds port dir (input, 1; 0 = up, 1 = down), sampled in the cycle the step occurs.
REQ-027 SEL_DOWN_EN undefined: no dir port; a always counts up.

Structure
REQ-028 Package sel_scan_pkg SHALL hold the FSM state encoding (IDLE=2'd0, PRESS_FILT=2'd1, HOLD=2'd2, REL_FILT=2'd3) and the default MAX constants.
REQ-029 The synchronizer and debounce FSM SHALL form sub-module key_filter (outputs key_flag); sel_scan instantiates it once.

Verification (DEB_CNT_MAX=4, DWELL_MAX=9)
REQ-030 Reset, then mode=0 with a clean key press held 20 cycles -> exactly one a_vld; a goes 0->1.
REQ-031 Key low for 3 cycles, high, then low for 3 cycles (bounce shorter than the filter) -> no a_vld; a stays at its value.
REQ-032 mode=0, four clean presses -> a = 1, 2, 3, 0, with four a_vld pulses.
REQ-033 mode=1 for 45 cycles -> a_vld every 10 cycles; a = 1, 2, 3, 0; key presses during the run have no effect.
REQ-034 sys_rst_n pulsed low while in PRESS_FILT, or at dwell_cnt=7 -> a=0, a_vld=0; the next step occurs only after a full filter or dwell period.
REQ-035 SEL_DOWN_EN with dir=1, mode=0, one press from reset -> a goes 0->3 with one a_vld.

Source files
------------

// File: rtl/sel_scan_pkg.sv
// Shared types and constants for the LED select scanner.
// State encoding for the key debouncer, default terminal counts, step helper.
package sel_scan_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HOLD       = 2'd2,
        REL_FILT   = 2'd3
    } deb_state_t;

    localparam logic [19:0] DEB_CNT_MAX_DEF = 20'd999_999;
    localparam logic [25:0] DWELL_MAX_DEF   = 26'd49_999_999;

    // Two-bit arithmetic gives the 3->0 and 0->3 wrap for free.
    function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic down);
        return down ? (cur - 2'd1) : (cur + 2'd1);
    endfunction

endpackage

// File: rtl/sel_scan_key_filter.sv
// Push-button conditioner: 2-flop synchronizer followed by a press/release
// debounce FSM that emits one key_flag pulse per debounced press.
module key_filter
    import sel_scan_pkg::*;
#(
    parameter logic [19:0] DEB_CNT_MAX = DEB_CNT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag
);

    logic        key_s1;
    logic        key_s2;
    deb_state_t  state;
    logic [19:0] deb_cnt;

    // Synchronizer flops reset high so a key held through reset is seen as a fresh press.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            state    <= IDLE;
            deb_cnt  <= 20'd0;
            key_flag <= 1'b0;
        end else begin
            key_s1   <= key_in;
            key_s2   <= key_s1;
            key_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s2) begin
                        state   <= PRESS_FILT;
                        deb_cnt <= 20'd0;
                    end
                end
                PRESS_FILT: begin
                    if (key_s2) begin
                        state   <= IDLE;
                        deb_cnt <= 20'd0;
                    end else if (deb_cnt == DEB_CNT_MAX) begin
                        state    <= HOLD;
                        deb_cnt  <= 20'd0;
                        key_flag <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 20'd1;
                    end
                end
                HOLD: begin
                    if (key_s2) begin
                        state   <= REL_FILT;
                        deb_cnt <= 20'd0;
                    end
                end
                REL_FILT: begin
                    if (!key_s2) begin
                        state   <= HOLD;
                        deb_cnt <= 20'd0;
                    end else if (deb_cnt == DEB_CNT_MAX) begin
                        state   <= IDLE;
                        deb_cnt <= 20'd0;
                    end else begin
                        deb_cnt <= deb_cnt + 20'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= 20'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sel_scan.sv
// 2-bit LED select scanner: steps on debounced key presses (manual) or every
// dwell period (auto). Optional SEL_DOWN_EN adds a 'dir' port for down-counting.
module sel_scan
    import sel_scan_pkg::*;
#(
    parameter logic [19:0] DEB_CNT_MAX = DEB_CNT_MAX_DEF,
    parameter logic [25:0] DWELL_MAX   = DWELL_MAX_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_in,
    input  logic       mode,
`ifdef SEL_DOWN_EN
    input  logic       dir,
`endif
    output logic [1:0] a,
    output logic       a_vld
);

    logic        key_flag;
    logic        mode_q;
    logic        down;
    logic [25:0] dwell_cnt;

`ifdef SEL_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    key_filter #(
        .DEB_CNT_MAX(DEB_CNT_MAX)
    ) u_key_filter (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_in   (key_in),
        .key_flag (key_flag)
    );

    // mode_q loads the live mode in reset so leaving reset is not seen as a mode change.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a         <= 2'b00;
            a_vld     <= 1'b0;
            dwell_cnt <= 26'd0;
            mode_q    <= mode;
        end else begin
            a_vld  <= 1'b0;
            mode_q <= mode;
            if (mode) begin
                if (mode != mode_q) begin
                    dwell_cnt <= 26'd0;
                end else if (dwell_cnt == DWELL_MAX) begin
                    dwell_cnt <= 26'd0;
                    a         <= next_sel(a, down);
                    a_vld     <= 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 26'd1;
                end
            end else begin
                dwell_cnt <= 26'd0;
                if (key_flag) begin
                    a     <= next_sel(a, down);
                    a_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sel_scan.sv
// Directed bench for sel_scan with short filter (4) and dwell (9) counts.
module tb_sel_scan;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_in = 1'b1;
    logic       mode = 1'b0;
`ifdef SEL_DOWN_EN
    logic       dir = 1'b0;
`endif
    logic [1:0] a;
    logic       a_vld;

    int check_count = 0;
    int pass_count  = 0;
    int vld_count   = 0;
    int base;

    sel_scan #(
        .DEB_CNT_MAX(20'd4),
        .DWELL_MAX  (26'd9)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_in   (key_in),
        .mode     (mode),
`ifdef SEL_DOWN_EN
        .dir      (dir),
`endif
        .a        (a),
        .a_vld    (a_vld)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (a_vld) vld_count++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected) pass_count++;
        else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Drive key_in, then let 'cycles' rising edges pass; returns 1 time unit after the last edge.
    task automatic applyStimulus(input logic key, input int cycles);
        key_in = key;
        repeat (cycles) @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        sys_rst_n = 1'b0;
        repeat (cycles) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic press(input int hold, input int rel);
        applyStimulus(1'b0, hold);
        applyStimulus(1'b1, rel);
    endtask

    initial begin
        @(posedge sys_clk);
        #1;
        apply_reset(2);
        checkOutput("reset_a", a, 0);
        checkOutput("reset_vld", a_vld, 0);

        // Clean press: a steps 9 edges after the key drops.
        base = vld_count;
        applyStimulus(1'b0, 8);
        checkOutput("press_a_before", a, 0);
        applyStimulus(1'b0, 1);
        checkOutput("press_a_step", a, 1);
        checkOutput("press_vld_step", a_vld, 1);
        applyStimulus(1'b0, 1);
        checkOutput("press_vld_pulse", a_vld, 0);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 20);
        checkOutput("press_vld_count", vld_count - base, 1);
        checkOutput("press_a_final", a, 1);

        // Bounces shorter than the filter.
        base = vld_count;
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 20);
        checkOutput("bounce_vld_count", vld_count - base, 0);
        checkOutput("bounce_a", a, 1);

        // Four presses from reset.
        apply_reset(1);
        checkOutput("reset2_a", a, 0);
        base = vld_count;
        for (int k = 1; k <= 4; k++) begin
            press(20, 20);
            checkOutput($sformatf("manual_a_%0d", k), a, k % 4);
        end
        checkOutput("manual_vld_count", vld_count - base, 4);

        // Auto run with a key press in the middle that must be ignored.
        base = vld_count;
        mode = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            applyStimulus((cyc >= 3 && cyc <= 22) ? 1'b0 : 1'b1, 1);
            if (cyc == 11 || cyc == 21 || cyc == 31 || cyc == 41) begin
                checkOutput($sformatf("auto_vld_c%0d", cyc), a_vld, 1);
                checkOutput($sformatf("auto_a_c%0d", cyc), a, (cyc / 10) % 4);
            end
            if (cyc == 15) checkOutput("auto_vld_gap", a_vld, 0);
        end
        checkOutput("auto_vld_count", vld_count - base, 4);

        // Continue auto to a=1, then reset at dwell_cnt=7.
        applyStimulus(1'b1, 13);
        checkOutput("dwell_pre_reset_a", a, 1);
        apply_reset(1);
        checkOutput("dwell_reset_a", a, 0);
        checkOutput("dwell_reset_vld", a_vld, 0);
        base = vld_count;
        applyStimulus(1'b1, 9);
        checkOutput("dwell_reset_quiet", vld_count - base, 0);
        applyStimulus(1'b1, 1);
        checkOutput("dwell_reset_step_vld", a_vld, 1);
        checkOutput("dwell_reset_step_a", a, 1);

        // Reset in PRESS_FILT with the key held low across reset release.
        mode = 1'b0;
        applyStimulus(1'b0, 4);
        apply_reset(1);
        checkOutput("filt_reset_a", a, 0);
        base = vld_count;
        applyStimulus(1'b0, 8);
        checkOutput("filt_reset_quiet", vld_count - base, 0);
        applyStimulus(1'b0, 1);
        checkOutput("filt_reset_step_vld", a_vld, 1);
        checkOutput("filt_reset_step_a", a, 1);
        applyStimulus(1'b1, 20);

`ifdef SEL_DOWN_EN
        dir = 1'b1;
        apply_reset(1);
        base = vld_count;
        press(20, 20);
        checkOutput("down_a", a, 3);
        checkOutput("down_vld_count", vld_count - base, 1);
        press(20, 20);
        checkOutput("down_a_2", a, 2);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
